// File: rtl/prio_enc_scan_pkg.sv
// Purpose : Shared constants and helpers for the prio_enc_scan display encoder.
//           Holds the active-low 7-segment patterns (bit0..6 = a..g, bit7 = dp)
//           and the function deriving the encoded index width.
// Ports   : none (package).
package prio_enc_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Hex glyphs 0-F, active-low, dp off.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Bits needed to hold an index 0..n-1 (at least 1).
    function automatic int code_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/prio_enc_scan_seg_hex.sv
// Purpose : Combinational 4-bit to 7-segment active-low decoder (dp off).
// Ports   : i_nib - hex digit to show
//           o_seg - active-low segment pattern, bit7 (dp) always 1
module prio_enc_scan_seg_hex
    import prio_enc_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_HEX[i_nib];

endmodule

// File: rtl/prio_enc_scan.sv
// Purpose : Registered N-input priority encoder with enable, hold and a
//           change-detect pulse, driving a scanned multi-digit hex display.
// Ports   : i_clk   - system clock, rising edge
//           i_rst_n - asynchronous active-low reset
//           i_code  - request lines, bit k = request k
//           i_en    - encoder enable
//           i_hold  - freeze the registered result (overrides i_en)
//           o_code  - index of the highest set request bit
//           o_valid - enabled and at least one request set
//           o_chg   - one-cycle pulse when {o_valid,o_code} changes
//           o_seg   - active-low segments, bit0..6 = a..g, bit7 = dp
//           o_an    - active-low one-hot digit select
module prio_enc_scan
    import prio_enc_scan_pkg::*;
#(
    parameter int N_IN     = 16,
    parameter int N_DIG    = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [N_IN-1:0]                 i_code,
    input  logic                            i_en,
    input  logic                            i_hold,
    output logic [code_width(N_IN)-1:0]     o_code,
    output logic                            o_valid,
    output logic                            o_chg,
    output logic [7:0]                      o_seg,
    output logic [N_DIG-1:0]                o_an
);

    localparam int W_CODE = code_width(N_IN);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [W_CODE-1:0]   r_code;
    logic                r_valid;
    logic                r_chg;
    logic [DIV_W-1:0]    r_div;
    logic [DIG_W-1:0]    r_dig;
    logic [7:0]          r_seg;
    logic [N_DIG-1:0]    r_an;

    logic [W_CODE-1:0]   w_idx;
    logic                w_any;
    logic [W_CODE-1:0]   w_code_nxt;
    logic                w_valid_nxt;
    logic [4*N_DIG-1:0]  w_code_ext;
    logic [3:0]          w_nib;
    logic [7:0]          w_hex;
    logic [7:0]          w_seg;
    logic [N_DIG-1:0]    w_an;

    // Ascending scan: the last (highest) set bit overwrites lower ones.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (i_code[k]) w_idx = W_CODE'(k);
        end
    end

    assign w_any = |i_code;

    always_comb begin
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        if (!i_hold) begin
            w_code_nxt  = i_en ? w_idx : '0;
            w_valid_nxt = i_en & w_any;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            // While held the next value equals the current one, so no pulse.
            r_chg   <= {w_valid_nxt, w_code_nxt} != {r_valid, r_code};
        end
    end

    // Free-running digit scan.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_dig <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_dig <= (r_dig == DIG_W'(N_DIG - 1)) ? '0 : r_dig + DIG_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        w_code_ext                = '0;
        w_code_ext[W_CODE-1:0]    = r_code;
    end

    assign w_nib = w_code_ext[4*r_dig +: 4];

    prio_enc_scan_seg_hex u_seg_hex (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    always_comb begin
        if (!r_valid) begin
            w_seg = SEG_DASH;
        end else if (r_dig == '0) begin
            w_seg = w_hex & 8'h7F;   // dp marks the least significant digit
        end else begin
            w_seg = w_hex;
        end
        w_an        = '1;
        w_an[r_dig] = 1'b0;
    end

    // Segment and anode registered on the same edge to avoid ghosting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= SEG_DASH;
            r_an  <= {{(N_DIG-1){1'b1}}, 1'b0};
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign o_code  = r_code;
    assign o_valid = r_valid;
    assign o_chg   = r_chg;
    assign o_seg   = r_seg;
    assign o_an    = r_an;

endmodule

// File: tb/tb_prio_enc_scan.sv
module tb_prio_enc_scan;

    localparam int N_IN     = 16;
    localparam int N_DIG    = 2;
    localparam int SCAN_DIV = 4;

    // Expected glyphs, active-low a..g, dp off.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic              i_clk;
    logic              i_rst_n;
    logic [N_IN-1:0]   i_code;
    logic              i_en;
    logic              i_hold;
    logic [3:0]        o_code;
    logic              o_valid;
    logic              o_chg;
    logic [7:0]        o_seg;
    logic [N_DIG-1:0]  o_an;

    prio_enc_scan #(
        .N_IN     (N_IN),
        .N_DIG    (N_DIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_code  (i_code),
        .i_en    (i_en),
        .i_hold  (i_hold),
        .o_code  (o_code),
        .o_valid (o_valid),
        .o_chg   (o_chg),
        .o_seg   (o_seg),
        .o_an    (o_an)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: encoder result and edges since reset release.
    int m_code;
    int m_valid;
    int m_chg;
    int n_edges;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_code  = 0;
        m_valid = 0;
        m_chg   = 0;
        n_edges = 0;
    endtask

    // Apply one cycle of inputs, advance the model, check every output.
    task automatic step(input logic [N_IN-1:0] c, input logic e, input logic h);
        int pc, pv, d, exp_an, exp_seg;
        i_code = c;
        i_en   = e;
        i_hold = h;
        @(posedge i_clk);
        pc = m_code;
        pv = m_valid;
        if (!h) begin
            m_code  = 0;
            m_valid = 0;
            if (e && c != 0) begin
                m_valid = 1;
                for (int k = N_IN - 1; k >= 0; k--) begin
                    if (c[k]) begin
                        m_code = k;
                        break;
                    end
                end
            end
        end
        m_chg = ((m_code != pc) || (m_valid != pv)) ? 1 : 0;
        n_edges++;
        // Display shows the digit selected before this edge, built from the
        // result registered before this edge.
        d       = ((n_edges - 1) / SCAN_DIV) % N_DIG;
        exp_an  = ~(1 << d) & ((1 << N_DIG) - 1);
        if (pv == 0) exp_seg = 8'hBF;
        else         exp_seg = GLYPH[(pc >> (4 * d)) & 15] & ((d == 0) ? 8'h7F : 8'hFF);
        @(negedge i_clk);
        chk("code",  32'(o_code),  32'(m_code));
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("chg",   32'(o_chg),   32'(m_chg));
        chk("an",    32'(o_an),    32'(exp_an));
        chk("seg",   32'(o_seg),   32'(exp_seg));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_code"},  32'(o_code),  32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_chg"},   32'(o_chg),   32'd0);
        chk({tag, "_seg"},   32'(o_seg),   32'hBF);
        chk({tag, "_an"},    32'(o_an),    32'h2);
    endtask

    initial begin
        logic [N_IN-1:0] c;
        int sel;
        i_rst_n = 1'b0;
        i_code  = '0;
        i_en    = 1'b0;
        i_hold  = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_reset_vals("rst");
        i_rst_n = 1'b1;

        // Encode 8421 -> F, then watch both digits.
        step(16'h8421, 1'b1, 1'b0);
        chk("enc_F", 32'(o_code), 32'hF);
        repeat (10) step(16'h8421, 1'b1, 1'b0);

        // Empty input and disabled encoder.
        repeat (3) step(16'h0000, 1'b1, 1'b0);
        step(16'h0001, 1'b1, 1'b0);
        repeat (2) step(16'h0001, 1'b0, 1'b0);

        // Hold freezes 4 while input moves to 8; release gives one pulse.
        step(16'h0010, 1'b1, 1'b0);
        repeat (3) step(16'h0100, 1'b1, 1'b1);
        step(16'h0100, 1'b0, 1'b1);
        chk("hold_4", 32'(o_code), 32'h4);
        step(16'h0100, 1'b1, 1'b0);
        chk("rel_8", 32'(o_code), 32'h8);
        repeat (2) step(16'h0100, 1'b1, 1'b0);

        // Scan with steady input.
        repeat (16) step(16'h0C00, 1'b1, 1'b0);

        // Priority sweep: single bit, then bit plus everything below it.
        for (int b = 0; b < N_IN; b++) step(16'(1 << b), 1'b1, 1'b0);
        for (int b = 0; b < N_IN; b++) step(16'((2 << b) - 1), 1'b1, 1'b0);

        // Asynchronous reset mid-scan with all requests set.
        repeat (5) step(16'hFFFF, 1'b1, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge i_clk);
        model_reset();
        i_rst_n = 1'b1;
        step(16'h0000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       c = '0;
                1:       c = 16'(1 << $urandom_range(0, N_IN - 1));
                default: c = 16'($urandom);
            endcase
            step(c, ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
